branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Dynamic branch predictor and branch target buffer (BTB) for the pipelined MIPS core.
- Fetch stage: combinationally predicts direction and target for the current PC.
- Resolve stage: the branch unit's resolved outcome trains the table and the block flags mispredictions.
- On a misprediction it issues a registered redirect PC for fetch and a flush request.
- Keeps saturating performance counters for branches resolved and mispredictions.

Parameters:
- PC_BITS, 32: PC width; PC is word-addressed, so the sequential PC is pc+1.
- INDEX_BITS, 4: BTB index width; DEPTH = 2**INDEX_BITS entries, direct-mapped.
- CNT_BITS, 2: width of the per-entry saturating direction counter (minimum 2).
- STAT_BITS, 16: width of each performance counter.

Ports:
- i_clock in 1: clock, rising edge.
- i_reset in 1: asynchronous, active-low reset.
- i_clear in 1: synchronous clear of all valid bits and both statistics counters.
- i_fetch_pc in PC_BITS: PC being fetched.
- o_predict_taken out 1: predicted taken for i_fetch_pc.
- o_predict_target out PC_BITS: predicted target; equals i_fetch_pc+1 when not predicted taken.
- i_update_valid in 1: one resolved branch or jump this cycle.
- i_update_is_jump in 1: unconditional instruction (J/JAL/JR/JALR).
- i_update_pc in PC_BITS: PC of the resolved instruction.
- i_update_taken in 1: actual direction.
- i_update_target in PC_BITS: actual target.
- i_update_pred_taken in 1: prediction carried down the pipe with the instruction.
- i_update_pred_target in PC_BITS: predicted target carried down the pipe.
- o_mispredict out 1: one-cycle pulse, registered.
- o_redirect_pc out PC_BITS: correct fetch PC; valid while o_mispredict is high.
- o_branch_count out STAT_BITS: resolved updates, saturating.
- o_mispredict_count out STAT_BITS: mispredictions, saturating.

Behaviour:
- Entry fields: valid, tag = pc[PC_BITS-1:INDEX_BITS], target, counter. Index = pc[INDEX_BITS-1:0].
- Reset (i_reset low, asynchronous): all valid bits 0; all counters set to weakly-not-taken (MSB 0, other bits 1; 01 for 2 bits); o_mispredict 0; o_redirect_pc 0; both statistics counters 0.
- Lookup is combinational from registered state. Hit = valid && tag match.
  - o_predict_taken = hit && counter MSB.
  - o_predict_target = stored target when o_predict_taken is high, otherwise i_fetch_pc+1 with wrap-around modulo 2**PC_BITS.
- Update is applied at the rising edge when i_update_valid is high.
  - Hit, conditional branch: counter increments if taken, decrements if not taken, saturating at all-ones and at 0. Target is overwritten when taken.
  - Hit, jump: counter forced to all-ones; target overwritten.
  - Miss and taken (branch or jump): allocate the entry, overwriting any previous occupant. Set tag and target. Counter = weakly-taken (MSB 1, other bits 0), or all-ones for a jump.
  - Miss and not taken: no allocation; the table is unchanged.
- No bypass: a lookup and an update to the same index in the same cycle returns the pre-update entry.
- Misprediction condition: (pred_taken != taken) || (taken && pred_target != target).
  - It is registered, so o_mispredict rises the cycle after the update and lasts exactly one cycle.
  - o_redirect_pc = taken ? target : update_pc+1.
  - o_mispredict is 0 in any cycle following one without i_update_valid.
- Statistics update at the same edge as the table:
  - o_branch_count += 1 per update.
  - o_mispredict_count += 1 per mispredicting update.
  - Both saturate at all-ones with no wrap.
- i_clear:
  - Clears valid bits and both statistics counters and forces o_mispredict to 0.
  - Counters and targets are left untouched.
  - Takes priority over a simultaneous update, which is discarded.
- Reset asserted mid-operation immediately restores all reset values. A pending o_mispredict is dropped.

Test Plan:
- Reset, then lookup at i_fetch_pc=5 -> o_predict_taken=0, o_predict_target=6. Both statistics counters read 0.
- BEQ at pc=5, taken, target=14, pred_taken=0 -> next cycle o_mispredict=1, o_redirect_pc=14; o_mispredict_count=1. A subsequent lookup at 5 -> taken, target 14 (counter 10).
- Two not-taken updates at pc=5 after the previous case -> counter 10 -> 01 -> 00. Lookup at 5 -> not taken, target 6. A third not-taken update keeps the counter at 00 (saturation).
- JAL at pc=21 (index 5, aliases pc=5), target=95 -> entry replaced with counter 11. Lookup at 21 -> taken/95. Lookup at 5 -> tag miss, not taken/6.
- Correct prediction: update at pc=21 with pred_taken=1, pred_target=95, taken, target 95 -> o_mispredict stays 0; o_branch_count increments.
- Wrap and saturation:
  - With STAT_BITS=2, four updates -> o_branch_count=3.
  - Lookup at pc=all-ones on a miss -> o_predict_target=0.
  - i_clear concurrent with an update -> the update is ignored and the counts read 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters, a registered
// misprediction redirect, and saturating resolved/mispredicted branch statistics.
module branch_predictor #(
    parameter int PC_BITS    = 32,
    parameter int INDEX_BITS = 4,
    parameter int CNT_BITS   = 2,
    parameter int STAT_BITS  = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic [PC_BITS-1:0]   i_fetch_pc,
    output logic                 o_predict_taken,
    output logic [PC_BITS-1:0]   o_predict_target,
    input  logic                 i_update_valid,
    input  logic                 i_update_is_jump,
    input  logic [PC_BITS-1:0]   i_update_pc,
    input  logic                 i_update_taken,
    input  logic [PC_BITS-1:0]   i_update_target,
    input  logic                 i_update_pred_taken,
    input  logic [PC_BITS-1:0]   i_update_pred_target,
    output logic                 o_mispredict,
    output logic [PC_BITS-1:0]   o_redirect_pc,
    output logic [STAT_BITS-1:0] o_branch_count,
    output logic [STAT_BITS-1:0] o_mispredict_count
);
    localparam int DEPTH    = 2 ** INDEX_BITS;
    localparam int TAG_BITS = PC_BITS - INDEX_BITS;

    localparam logic [CNT_BITS-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_BITS-1:0]  CNT_WNT  = CNT_MAX >> 1;
    localparam logic [CNT_BITS-1:0]  CNT_WT   = ~CNT_WNT;
    localparam logic [CNT_BITS-1:0]  CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [STAT_BITS-1:0] STAT_MAX = '1;
    localparam logic [STAT_BITS-1:0] STAT_ONE = {{(STAT_BITS-1){1'b0}}, 1'b1};
    localparam logic [PC_BITS-1:0]   PC_ONE   = {{(PC_BITS-1){1'b0}}, 1'b1};

    function automatic logic [CNT_BITS-1:0] cnt_inc(input logic [CNT_BITS-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_ONE;
    endfunction

    function automatic logic [CNT_BITS-1:0] cnt_dec(input logic [CNT_BITS-1:0] c);
        return (c == '0) ? c : c - CNT_ONE;
    endfunction

    function automatic logic [STAT_BITS-1:0] stat_inc(input logic [STAT_BITS-1:0] s);
        return (s == STAT_MAX) ? s : s + STAT_ONE;
    endfunction

    logic [DEPTH-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q    [DEPTH];
    logic [PC_BITS-1:0]  target_q [DEPTH];
    logic [CNT_BITS-1:0] cnt_q    [DEPTH];

    logic                 mispredict_q;
    logic [PC_BITS-1:0]   redirect_q;
    logic [STAT_BITS-1:0] branch_cnt_q;
    logic [STAT_BITS-1:0] mispred_cnt_q;

    logic [INDEX_BITS-1:0] f_idx;
    logic                  f_hit;

    assign f_idx = i_fetch_pc[INDEX_BITS-1:0];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == i_fetch_pc[PC_BITS-1:INDEX_BITS]);

    assign o_predict_taken  = f_hit && cnt_q[f_idx][CNT_BITS-1];
    assign o_predict_target = o_predict_taken ? target_q[f_idx] : i_fetch_pc + PC_ONE;

    logic [INDEX_BITS-1:0] u_idx;
    logic [TAG_BITS-1:0]   u_tag;
    logic                  u_hit;
    logic                  wr_en;
    logic                  tgt_wr;
    logic [CNT_BITS-1:0]   cnt_d;
    logic                  mispredict_d;

    assign u_idx = i_update_pc[INDEX_BITS-1:0];
    assign u_tag = i_update_pc[PC_BITS-1:INDEX_BITS];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    // A not-taken miss leaves the table alone; clear discards the update.
    assign wr_en = i_update_valid && !i_clear && (u_hit || i_update_taken);

    assign mispredict_d = i_update_valid &&
                          ((i_update_pred_taken != i_update_taken) ||
                           (i_update_taken && (i_update_pred_target != i_update_target)));

    always_comb begin
        cnt_d  = cnt_q[u_idx];
        tgt_wr = 1'b0;
        if (u_hit) begin
            if (i_update_is_jump) begin
                cnt_d  = CNT_MAX;
                tgt_wr = 1'b1;
            end else if (i_update_taken) begin
                cnt_d  = cnt_inc(cnt_q[u_idx]);
                tgt_wr = 1'b1;
            end else begin
                cnt_d  = cnt_dec(cnt_q[u_idx]);
            end
        end else begin
            cnt_d  = i_update_is_jump ? CNT_MAX : CNT_WT;
            tgt_wr = 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_WNT;
        end else if (i_clear) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[u_idx] <= 1'b1;
            cnt_q[u_idx]   <= cnt_d;
        end
    end

    always_ff @(posedge i_clock) begin
        if (wr_en) begin
            tag_q[u_idx] <= u_tag;
            if (tgt_wr) target_q[u_idx] <= i_update_target;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            mispredict_q  <= 1'b0;
            redirect_q    <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else if (i_clear) begin
            mispredict_q  <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            mispredict_q <= mispredict_d;
            if (mispredict_d) begin
                redirect_q    <= i_update_taken ? i_update_target : i_update_pc + PC_ONE;
                mispred_cnt_q <= stat_inc(mispred_cnt_q);
            end
            if (i_update_valid) branch_cnt_q <= stat_inc(branch_cnt_q);
        end
    end

    assign o_mispredict       = mispredict_q;
    assign o_redirect_pc      = redirect_q;
    assign o_branch_count     = branch_cnt_q;
    assign o_mispredict_count = mispred_cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a table of update/lookup cycles on the
// default configuration plus hand sequences for stat saturation and async reset.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [31:0] fpc;
    logic        pt;
    logic [31:0] ptgt;
    logic        uv, uj, ut, upt;
    logic [31:0] upc, utgt, uptgt;
    logic        mis;
    logic [31:0] redir;
    logic [15:0] bc, mc;

    logic        s_clr;
    logic [31:0] s_fpc;
    logic        s_pt;
    logic [31:0] s_ptgt;
    logic        s_uv, s_uj, s_ut, s_upt;
    logic [31:0] s_upc, s_utgt, s_uptgt;
    logic        s_mis;
    logic [31:0] s_redir;
    logic [1:0]  s_bc, s_mc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .i_clock(clk), .i_reset(rst_n), .i_clear(clr),
        .i_fetch_pc(fpc), .o_predict_taken(pt), .o_predict_target(ptgt),
        .i_update_valid(uv), .i_update_is_jump(uj), .i_update_pc(upc),
        .i_update_taken(ut), .i_update_target(utgt),
        .i_update_pred_taken(upt), .i_update_pred_target(uptgt),
        .o_mispredict(mis), .o_redirect_pc(redir),
        .o_branch_count(bc), .o_mispredict_count(mc)
    );

    branch_predictor #(.STAT_BITS(2)) dut_s (
        .i_clock(clk), .i_reset(rst_n), .i_clear(s_clr),
        .i_fetch_pc(s_fpc), .o_predict_taken(s_pt), .o_predict_target(s_ptgt),
        .i_update_valid(s_uv), .i_update_is_jump(s_uj), .i_update_pc(s_upc),
        .i_update_taken(s_ut), .i_update_target(s_utgt),
        .i_update_pred_taken(s_upt), .i_update_pred_target(s_uptgt),
        .o_mispredict(s_mis), .o_redirect_pc(s_redir),
        .o_branch_count(s_bc), .o_mispredict_count(s_mc)
    );

    typedef struct {
        logic        uv, uj, ut, upt, clr;
        logic [31:0] upc, utgt, uptgt, fpc;
        logic        e_pt;
        logic [31:0] e_tgt;
        logic        e_mis;
        logic [31:0] e_red;
        logic [15:0] e_bc, e_mc;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(
        input logic v, j, t, p, c,
        input logic [31:0] pc, tg, ptg, f,
        input logic ept, input logic [31:0] etg,
        input logic emis, input logic [31:0] ered,
        input logic [15:0] ebc, emc);
        vec_t r;
        r.uv = v; r.uj = j; r.ut = t; r.upt = p; r.clr = c;
        r.upc = pc; r.utgt = tg; r.uptgt = ptg; r.fpc = f;
        r.e_pt = ept; r.e_tgt = etg; r.e_mis = emis; r.e_red = ered;
        r.e_bc = ebc; r.e_mc = emc;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        //           uv uj ut upt clr  upc utgt uptgt fpc         pt  tgt  mis red  bc mc
        vecs[0]  = mk(1, 0, 1, 0, 0,    5, 14,  0,    5,          1, 14,   1, 14,  1, 1);
        vecs[1]  = mk(1, 0, 0, 1, 0,    5,  0, 14,    5,          0,  6,   1,  6,  2, 2);
        vecs[2]  = mk(1, 0, 0, 0, 0,    5,  0,  0,    5,          0,  6,   0,  0,  3, 2);
        vecs[3]  = mk(1, 0, 0, 0, 0,    5,  0,  0,    5,          0,  6,   0,  0,  4, 2);
        vecs[4]  = mk(1, 0, 1, 0, 0,    5, 14,  0,    5,          0,  6,   1, 14,  5, 3);
        vecs[5]  = mk(1, 1, 1, 0, 0,   21, 95,  0,   21,          1, 95,   1, 95,  6, 4);
        vecs[6]  = mk(0, 0, 0, 0, 0,    0,  0,  0,    5,          0,  6,   0,  0,  6, 4);
        vecs[7]  = mk(1, 0, 1, 1, 0,   21, 95, 95,   21,          1, 95,   0,  0,  7, 4);
        vecs[8]  = mk(1, 0, 1, 1, 0,   21, 40, 95,   21,          1, 40,   1, 40,  8, 5);
        vecs[9]  = mk(0, 0, 0, 0, 0,    0,  0,  0, 32'hFFFFFFFF,  0,  0,   0,  0,  8, 5);
        vecs[10] = mk(1, 0, 0, 1, 0,    7,  0,  0,    7,          0,  8,   1,  8,  9, 6);
        vecs[11] = mk(1, 0, 1, 0, 1,    7,  3,  0,   21,          0, 22,   0,  0,  0, 0);
        vecs[12] = mk(1, 0, 1, 0, 0,    7,  3,  0,    7,          1,  3,   1,  3,  1, 1);
        vecs[13] = mk(1, 0, 0, 0, 0,   21,  0,  0,   21,          0, 22,   0,  0,  2, 1);
        vecs[14] = mk(1, 0, 1, 0, 0,   21, 50,  0,   21,          1, 50,   1, 50,  3, 2);
        vecs[15] = mk(1, 0, 0, 1, 0,   21,  0, 50,   21,          0, 22,   1, 22,  4, 3);

        rst_n = 1'b0; clr = 1'b0; fpc = 32'd5;
        uv = 0; uj = 0; ut = 0; upt = 0; upc = '0; utgt = '0; uptgt = '0;
        s_clr = 1'b0; s_fpc = '0;
        s_uv = 0; s_uj = 0; s_ut = 0; s_upt = 0; s_upc = '0; s_utgt = '0; s_uptgt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        #1;
        chk("reset_pt",    32'(pt), 32'd0);
        chk("reset_tgt",   ptgt, 32'd6);
        chk("reset_mis",   32'(mis), 32'd0);
        chk("reset_redir", redir, 32'd0);
        chk("reset_bc",    32'(bc), 32'd0);
        chk("reset_mc",    32'(mc), 32'd0);

        for (int i = 0; i < 16; i++) begin
            uv = vecs[i].uv; uj = vecs[i].uj; ut = vecs[i].ut; upt = vecs[i].upt;
            clr = vecs[i].clr; upc = vecs[i].upc; utgt = vecs[i].utgt;
            uptgt = vecs[i].uptgt; fpc = vecs[i].fpc;
            @(posedge clk);
            #1;
            uv = 1'b0; clr = 1'b0;
            chk($sformatf("v%0d_pt", i),  32'(pt), 32'(vecs[i].e_pt));
            chk($sformatf("v%0d_tgt", i), ptgt, vecs[i].e_tgt);
            chk($sformatf("v%0d_mis", i), 32'(mis), 32'(vecs[i].e_mis));
            if (vecs[i].e_mis) chk($sformatf("v%0d_redir", i), redir, vecs[i].e_red);
            chk($sformatf("v%0d_bc", i),  32'(bc), 32'(vecs[i].e_bc));
            chk($sformatf("v%0d_mc", i),  32'(mc), 32'(vecs[i].e_mc));
        end

        // Narrow statistics counters must stick at all-ones.
        s_uv = 1; s_ut = 1; s_upt = 0; s_upc = 32'd1; s_utgt = 32'd9;
        repeat (4) @(posedge clk);
        #1;
        chk("sat4_bc", 32'(s_bc), 32'd3);
        chk("sat4_mc", 32'(s_mc), 32'd3);
        @(posedge clk);
        #1;
        s_uv = 0;
        chk("sat5_bc", 32'(s_bc), 32'd3);
        chk("sat5_mc", 32'(s_mc), 32'd3);

        // Asynchronous reset mid-cycle drops a pending mispredict.
        uv = 1; uj = 0; ut = 1; upt = 0; upc = 32'd9; utgt = 32'd2; fpc = 32'd9;
        @(posedge clk);
        #1;
        uv = 0;
        chk("pre_rst_mis",   32'(mis), 32'd1);
        chk("pre_rst_redir", redir, 32'd2);
        chk("pre_rst_bc",    32'(bc), 32'd5);
        chk("pre_rst_pt",    32'(pt), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mis",   32'(mis), 32'd0);
        chk("rst_redir", redir, 32'd0);
        chk("rst_bc",    32'(bc), 32'd0);
        chk("rst_mc",    32'(mc), 32'd0);
        chk("rst_pt",    32'(pt), 32'd0);
        chk("rst_tgt",   ptgt, 32'd10);
        chk("rst_s_bc",  32'(s_bc), 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_mis", 32'(mis), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
